// File: rtl/serial_adder_ctrl_pkg.sv
// Shared constants and types for the nibble-serial adder controller.
package serial_adder_ctrl_pkg;

  localparam int unsigned NIB = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Requester-side handshake and operand/result bundle for serial_adder_ctrl.
interface serial_adder_ctrl_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  ready, busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output ready, busy, done, sum, cout
  );

endinterface

// File: rtl/serial_adder_ctrl_slice.sv
// 4-bit combinational ripple-carry slice built from 1-bit full adders.
module nibble_adder_slice
  import serial_adder_ctrl_pkg::*;
(
  input  logic [NIB-1:0] x,
  input  logic [NIB-1:0] y,
  input  logic           ci,
  output logic [NIB-1:0] s,
  output logic           co
);

  logic [NIB:0] c;

  assign c[0] = ci;

  for (genvar gi = 0; gi < NIB; gi++) begin : g_fa
    assign s[gi]   = x[gi] ^ y[gi] ^ c[gi];
    assign c[gi+1] = (x[gi] & y[gi]) | (c[gi] & (x[gi] ^ y[gi]));
  end

  assign co = c[NIB];

endmodule

// File: rtl/serial_adder_ctrl.sv
// Wide adder that reuses one 4-bit slice over WIDTH/4 passes, LSB nibble first.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_ctrl_if.slave  bus
);

  localparam int unsigned NIBBLES = WIDTH / NIB;
  localparam int unsigned IdxW    = $clog2(NIBBLES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [NIB-1:0]   x_nib, y_nib, s_nib;
  logic             co_nib;

  assign x_nib = a_q[idx_q*NIB +: NIB];
  assign y_nib = b_q[idx_q*NIB +: NIB];

  nibble_adder_slice u_slice (
    .x  (x_nib),
    .y  (y_nib),
    .ci (carry_q),
    .s  (s_nib),
    .co (co_nib)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StRun;
      StRun:   if (idx_q == LastIdx) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: operands only load on the accepting edge
  always_comb begin
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          idx_d   = '0;
          sum_d   = '0;
        end
      end
      StRun: begin
        sum_d[idx_q*NIB +: NIB] = s_nib;
        carry_d = co_nib;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LastIdx) cout_d = co_nib;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Outputs decoded from registers only
  always_comb begin
    bus.ready = (state_q == StIdle);
    bus.busy  = (state_q == StRun);
    bus.done  = (state_q == StDone);
    bus.sum   = sum_q;
    bus.cout  = cout_q;
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and back-to-back random checks of serial_adder_ctrl at WIDTH=16.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_ctrl_if #(.WIDTH(16)) bus ();

  serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Drive operands with start, let the accepting edge pass, then drop start.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic cin);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Count negedges after acceptance until done; lat=-1 if it never comes.
  task automatic wait_done(output int lat, output int nbusy);
    lat   = -1;
    nbusy = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) nbusy++;
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", bus.ready); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", bus.done); end
    total++; if (bus.sum !== 16'h0000) begin bad++; $display("FAIL rst_sum got=%h exp=0000", bus.sum); end
    total++; if (bus.cout !== 1'b0) begin bad++; $display("FAIL rst_cout got=%b exp=0", bus.cout); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b exp=1", bus.ready); end
  endtask

  task automatic test_basic();
    int lat, nbusy;
    issue(16'h1234, 16'h4321, 1'b0);
    wait_done(lat, nbusy);
    total++; if (lat != 5) begin bad++; $display("FAIL basic_latency got=%0d exp=5", lat); end
    total++; if (nbusy != 4) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=4", nbusy); end
    total++; if (bus.sum !== 16'h5555) begin bad++; $display("FAIL basic_sum got=%h exp=5555", bus.sum); end
    total++; if (bus.cout !== 1'b0) begin bad++; $display("FAIL basic_cout got=%b exp=0", bus.cout); end
    @(negedge clk);
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b exp=0", bus.done); end
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL basic_back_idle got=%b exp=1", bus.ready); end
    total++; if (bus.sum !== 16'h5555) begin bad++; $display("FAIL basic_sum_hold got=%h exp=5555", bus.sum); end
  endtask

  task automatic test_carry_chain();
    issue(16'hFFFF, 16'h0001, 1'b0);
    total++; if (dut.carry_q !== 1'b0) begin bad++; $display("FAIL carry_init got=%b exp=0", dut.carry_q); end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (dut.carry_q !== 1'b1) begin
        bad++; $display("FAIL carry_pass%0d got=%b exp=1", k, dut.carry_q);
      end
    end
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL carry_done got=%b exp=1", bus.done); end
    total++; if (bus.sum !== 16'h0000) begin bad++; $display("FAIL carry_sum got=%h exp=0000", bus.sum); end
    total++; if (bus.cout !== 1'b1) begin bad++; $display("FAIL carry_cout got=%b exp=1", bus.cout); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ignore_start();
    int ndone;
    ndone = 0;
    issue(16'h0F0F, 16'h0101, 1'b0);
    bus.start = 1'b1;
    bus.a     = 16'hFFFF;
    bus.b     = 16'hFFFF;
    bus.cin   = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ndone++;
        // Keep start high through DONE, drop it before the IDLE edge
        @(posedge clk);
        #1 bus.start = 1'b0;
      end
    end
    total++; if (ndone != 1) begin bad++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
    total++; if (bus.sum !== 16'h1010) begin bad++; $display("FAIL ignore_sum got=%h exp=1010", bus.sum); end
    total++; if (bus.cout !== 1'b0) begin bad++; $display("FAIL ignore_cout got=%b exp=0", bus.cout); end
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL ignore_idle got=%b exp=1", bus.ready); end
  endtask

  task automatic test_corners();
    logic [15:0] va [2] = '{16'h0000, 16'hFFFF};
    logic [15:0] vb [2] = '{16'h0000, 16'hFFFF};
    logic        vc [2] = '{1'b1, 1'b1};
    logic [15:0] es [2] = '{16'h0001, 16'hFFFF};
    logic        ec [2] = '{1'b0, 1'b1};
    int lat, nbusy;
    for (int i = 0; i < 2; i++) begin
      issue(va[i], vb[i], vc[i]);
      wait_done(lat, nbusy);
      total++; if (lat != 5) begin bad++; $display("FAIL corner%0d_latency got=%0d exp=5", i, lat); end
      total++; if (bus.sum !== es[i]) begin bad++; $display("FAIL corner%0d_sum got=%h exp=%h", i, bus.sum, es[i]); end
      total++; if (bus.cout !== ec[i]) begin bad++; $display("FAIL corner%0d_cout got=%b exp=%b", i, bus.cout, ec[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_run();
    int ndone, lat, nbusy;
    ndone = 0;
    issue(16'h00FF, 16'h00FF, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.sum !== 16'h00FE) begin bad++; $display("FAIL mid_partial got=%h exp=00fe", bus.sum); end
    rst = 1'b1;
    #1;
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got=%b exp=1", bus.ready); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b exp=0", bus.busy); end
    total++; if (bus.sum !== 16'h0000) begin bad++; $display("FAIL mid_rst_sum got=%h exp=0000", bus.sum); end
    total++; if (bus.cout !== 1'b0) begin bad++; $display("FAIL mid_rst_cout got=%b exp=0", bus.cout); end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    total++; if (ndone != 0) begin bad++; $display("FAIL mid_no_done got=%0d exp=0", ndone); end
    @(posedge clk);
    #1;
    issue(16'h00FF, 16'h00FF, 1'b0);
    wait_done(lat, nbusy);
    total++; if (lat != 5) begin bad++; $display("FAIL mid_after_latency got=%0d exp=5", lat); end
    total++; if (bus.sum !== 16'h01FE) begin bad++; $display("FAIL mid_after_sum got=%h exp=01fe", bus.sum); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [15:0] ra, rb;
    logic        rc;
    logic [16:0] exp_v;
    int          acc, prev_acc, lat, nbusy;
    prev_acc = 0;
    bus.start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      bus.a   = ra;
      bus.b   = rb;
      bus.cin = rc;
      exp_v = {1'b0, ra} + {1'b0, rb} + {16'h0000, rc};
      for (int w = 0; w < 10; w++) begin
        @(negedge clk);
        if (bus.ready === 1'b1) break;
      end
      @(posedge clk);
      #1;
      acc = cyc;
      if (i > 0) begin
        total++;
        if (acc - prev_acc != 6) begin
          bad++; $display("FAIL b2b_interval%0d got=%0d exp=6", i, acc - prev_acc);
        end
      end
      prev_acc = acc;
      wait_done(lat, nbusy);
      total++;
      if ({bus.cout, bus.sum} !== exp_v) begin
        bad++;
        $display("FAIL b2b_result%0d a=%h b=%h cin=%b got=%h exp=%h", i, ra, rb, rc,
                 {bus.cout, bus.sum}, exp_v);
      end
    end
    bus.start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_chain();
    test_ignore_start();
    test_corners();
    test_reset_mid_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Multi-cycle wide adder: sequences one shared 4-bit ripple-carry slice over WIDTH/4 nibbles, LSB nibble first.
- A register between nibbles holds the carry from one nibble to the next.
- Sits between a requester that issues start/operands and the 4-bit adder datapath.
- Trades latency for area: one slice instead of WIDTH/4 slices.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and ≥ 8.
- NIBBLES, WIDTH/4, derived local constant; number of slice passes.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only while ready=1.
- a  input  WIDTH  operand A; sampled on the accepting edge only.
- b  input  WIDTH  operand B; sampled on the accepting edge only.
- cin  input  1  carry-in; sampled on the accepting edge only.
- ready  output  1  high in IDLE.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result; registered.
- cout  output  1  final carry-out; registered.

Behaviour:
- Reset (async, any state): state=IDLE, nibble index=0, carry reg=0, operand regs=0, sum=0, cout=0, done=0, busy=0, ready=1.
- States: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - If start=1 on an edge: latch a, b; carry reg←cin; index←0; clear sum to 0; go to RUN.
  - If start=0: stay in IDLE.
- RUN, one nibble per cycle:
  - Slice inputs are operand nibble[index] and the carry reg.
  - On the edge: sum nibble[index]←slice sum; carry reg←slice cout; index←index+1.
  - When index==NIBBLES-1 on that edge: cout←slice cout, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally. ready=0 here, so start is ignored in DONE.
- Latency: accepting edge at cycle T → done high in cycle T+NIBBLES+1. Throughput is one operation per NIBBLES+2 cycles.
- start while busy or in DONE: ignored; no effect on operands or result.
- sum/cout:
  - Hold their value after DONE until the next accepted start.
  - Partial sum is visible during RUN and is not valid until done.
- Arithmetic:
  - Unsigned modulo 2^WIDTH; {cout,sum} = a + b + cin exactly.
  - No overflow flag.
- Reset mid-RUN: operation aborted, all outputs return to reset values immediately. No done pulse for the aborted operation.
- Outputs ready/busy/done are decoded directly from the state register. No combinational path from start to any output.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the slice width constant NIB=4.
- One sub-module: nibble_adder_slice.
  - 4-bit combinational ripple-carry adder built from 1-bit full adders.
  - Ports: x[3:0], y[3:0], ci, s[3:0], co.
- Controller owns all registers and the nibble mux/demux indexed by the nibble counter.
- Nibble counter width is $clog2(NIBBLES).

Test Plan:
- WIDTH=16, a=16'h1234, b=16'h4321, cin=0, start pulsed at T → busy for 4 cycles, done at T+5, sum=16'h5555, cout=0.
- a=16'hFFFF, b=16'h0001, cin=0 → sum=16'h0000, cout=1. Carry propagates through all 4 passes; check carry reg=1 after each RUN edge.
- a=16'h0000, b=16'h0000, cin=1 → sum=16'h0001, cout=0. a=16'hFFFF, b=16'hFFFF, cin=1 → sum=16'hFFFF, cout=1.
- Accept a=16'h0F0F, b=16'h0101. Assert start with a=16'hFFFF during RUN and DONE → ignored; result sum=16'h1010, cout=0; exactly one done pulse.
- Assert rst after 2 RUN cycles → immediately ready=1, busy=0, sum=0, cout=0; no done pulse. New start after reset release completes normally.
- Back-to-back: start held high continuously → operations accepted every 6 cycles (NIBBLES+2). Each result is correct and matches a reference model {cout,sum}=a+b+cin over 200 random vectors.
